// File: rtl/bnn_neuron_seq_if.sv
// Shared word-addressed read port used by the multi-word BNN neuron sequencer.
// One outstanding read at a time: req/addr until gnt, then data on a later rvalid.
interface bnn_neuron_seq_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/bnn_neuron_seq.sv
// Multi-word binary neuron: fetches activation/weight word pairs, XNOR-popcounts them
// with tail masking, then forms the +/-1 dot-product score and the thresholded activation.
module bnn_neuron_seq #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_bits,
    input  logic [31:0]         threshold,
    input  logic [ADDR_W-1:0]   act_base,
    input  logic [ADDR_W-1:0]   wgt_base,
    bnn_neuron_seq_if.master    mem,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    pop_count,
    output logic [31:0]         score,
    output logic                act_out
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        WAIT_A,
        FETCH_W,
        WAIT_W,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_bits_q, n_bits_d;
    logic [CNT_W-1:0]    n_words_q, n_words_d;
    logic [31:0]         thr_q, thr_d;
    logic [ADDR_W-1:0]   act_base_q, act_base_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [31:0]         act_word_q, act_word_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    pop_count_q, pop_count_d;
    logic [31:0]         score_q, score_d;
    logic                act_out_q, act_out_d;

    logic                mem_req_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic                is_last;
    logic [4:0]          tail_bits;
    logic [31:0]         xnor_word;
    logic [31:0]         tail_mask;
    logic [31:0]         masked_word;
    logic [5:0]          word_pop;

    // Per-word datapath: only the final word of a vector that is not a multiple
    // of 32 bits carries padding bits, which must not count as matches.
    always_comb begin
        is_last     = (idx_q == (n_words_q - CNT_W'(1)));
        tail_bits   = n_bits_q[4:0];
        xnor_word   = ~(act_word_q ^ mem.mem_rdata);
        tail_mask   = '1;
        if (is_last && (tail_bits != 5'd0)) begin
            tail_mask = (32'd1 << tail_bits) - 32'd1;
        end
        masked_word = xnor_word & tail_mask;
        word_pop    = '0;
        for (int b = 0; b < 32; b++) begin
            word_pop = word_pop + 6'(masked_word[b]);
        end
    end

    always_comb begin
        state_d     = state_q;
        n_bits_d    = n_bits_q;
        n_words_d   = n_words_q;
        thr_d       = thr_q;
        act_base_d  = act_base_q;
        wgt_base_d  = wgt_base_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        act_word_d  = act_word_q;
        done_d      = 1'b0;
        pop_count_d = pop_count_q;
        score_d     = score_q;
        act_out_d   = act_out_q;
        mem_req_c   = 1'b0;
        mem_addr_c  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_bits_d    = n_bits;
                    n_words_d   = CNT_W'(({1'b0, n_bits} + (CNT_W+1)'(31)) >> 5);
                    thr_d       = threshold;
                    act_base_d  = act_base;
                    wgt_base_d  = wgt_base;
                    idx_d       = '0;
                    acc_d       = '0;
                    pop_count_d = '0;
                    score_d     = '0;
                    act_out_d   = 1'b0;
                    state_d     = (n_bits == '0) ? FINISH : FETCH_A;
                end
            end
            FETCH_A: begin
                mem_req_c  = 1'b1;
                mem_addr_c = act_base_q + ADDR_W'(idx_q);
                if (mem.mem_gnt) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_A: begin
                if (mem.mem_rvalid) begin
                    act_word_d = mem.mem_rdata;
                    state_d    = FETCH_W;
                end
            end
            FETCH_W: begin
                mem_req_c  = 1'b1;
                mem_addr_c = wgt_base_q + ADDR_W'(idx_q);
                if (mem.mem_gnt) begin
                    state_d = WAIT_W;
                end
            end
            WAIT_W: begin
                if (mem.mem_rvalid) begin
                    acc_d = acc_q + CNT_W'(word_pop);
                    if (is_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = FETCH_A;
                    end
                end
            end
            FINISH: begin
                // Matches minus mismatches equals 2*matches - n_bits.
                done_d      = 1'b1;
                pop_count_d = acc_q;
                score_d     = (32'(acc_q) << 1) - 32'(n_bits_q);
                act_out_d   = ($signed(score_d) >= $signed(thr_q));
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_bits_q    <= '0;
            n_words_q   <= '0;
            thr_q       <= '0;
            act_base_q  <= '0;
            wgt_base_q  <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            act_word_q  <= '0;
            done_q      <= 1'b0;
            pop_count_q <= '0;
            score_q     <= '0;
            act_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_bits_q    <= n_bits_d;
            n_words_q   <= n_words_d;
            thr_q       <= thr_d;
            act_base_q  <= act_base_d;
            wgt_base_q  <= wgt_base_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            act_word_q  <= act_word_d;
            done_q      <= done_d;
            pop_count_q <= pop_count_d;
            score_q     <= score_d;
            act_out_q   <= act_out_d;
        end
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_addr = mem_addr_c;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign pop_count    = pop_count_q;
    assign score        = score_q;
    assign act_out      = act_out_q;

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Directed bench for bnn_neuron_seq: table of hand-computed vectors plus
// hand-written gnt-stall, start-while-busy and reset-mid-operation sequences.
module tb_bnn_neuron_seq;

    typedef struct {
        logic [15:0] n_bits;
        logic [31:0] thr;
        logic [7:0]  act_base;
        logic [7:0]  wgt_base;
        logic [31:0] act0;
        logic [31:0] wgt0;
        logic [31:0] act1;
        logic [31:0] wgt1;
        logic [15:0] exp_pop;
        logic [31:0] exp_score;
        logic        exp_act;
        int          exp_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] n_bits;
    logic [31:0] threshold;
    logic [7:0]  act_base;
    logic [7:0]  wgt_base;
    logic        busy;
    logic        done;
    logic [15:0] pop_count;
    logic [31:0] score;
    logic        act_out;
    logic        gnt_en;

    logic [31:0] mem_arr [256];
    logic [7:0]  addr_log [$];
    vec_t        vecs [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    bnn_neuron_seq_if #(.ADDR_W(8)) mem_if ();

    bnn_neuron_seq #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_bits    (n_bits),
        .threshold (threshold),
        .act_base  (act_base),
        .wgt_base  (wgt_base),
        .mem       (mem_if.master),
        .busy      (busy),
        .done      (done),
        .pop_count (pop_count),
        .score     (score),
        .act_out   (act_out)
    );

    always #5 clk = ~clk;

    // Memory model: grant when enabled, data returned exactly one cycle after grant.
    assign mem_if.mem_gnt = mem_if.mem_req & gnt_en;

    always @(posedge clk) begin
        mem_if.mem_rvalid <= mem_if.mem_req & mem_if.mem_gnt;
        mem_if.mem_rdata  <= mem_arr[mem_if.mem_addr];
        if (mem_if.mem_req && mem_if.mem_gnt) begin
            addr_log.push_back(mem_if.mem_addr);
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int stall, input int poke_at, input string tag);
        int         cycles;
        int         w;
        logic [7:0] a;
        w = (int'(v.n_bits) + 31) / 32;
        mem_arr[v.act_base] = v.act0;
        mem_arr[v.wgt_base] = v.wgt0;
        a = v.act_base + 8'd1;
        mem_arr[a] = v.act1;
        a = v.wgt_base + 8'd1;
        mem_arr[a] = v.wgt1;

        @(negedge clk);
        addr_log.delete();
        n_bits    = v.n_bits;
        threshold = v.thr;
        act_base  = v.act_base;
        wgt_base  = v.wgt_base;
        gnt_en    = (stall == 0);
        start     = 1'b1;
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        start = 1'b0;
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        check_output({tag, "_clr_pop"}, 32'(pop_count), 32'd0);
        check_output({tag, "_clr_score"}, score, 32'd0);
        check_output({tag, "_clr_act"}, 32'(act_out), 32'd0);

        for (int k = 0; k < stall; k++) begin
            check_output({tag, "_stall_req"}, 32'(mem_if.mem_req), 32'd1);
            check_output({tag, "_stall_addr"}, 32'(mem_if.mem_addr), 32'(v.act_base));
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        gnt_en = 1'b1;

        while (!done && cycles < 300) begin
            if (cycles == poke_at) begin
                start     = 1'b1;
                n_bits    = 16'd9;
                threshold = 32'h7FFF_FFFF;
                act_base  = 8'hAA;
                wgt_base  = 8'hBB;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;

        check_output({tag, "_done"}, 32'(done), 32'd1);
        check_output({tag, "_cycles"}, 32'(cycles), 32'(v.exp_cycles + stall));
        check_output({tag, "_pop"}, 32'(pop_count), 32'(v.exp_pop));
        check_output({tag, "_score"}, score, v.exp_score);
        check_output({tag, "_act"}, 32'(act_out), 32'(v.exp_act));
        check_output({tag, "_naddr"}, 32'(addr_log.size()), 32'(2 * w));
        for (int i = 0; i < w && i < addr_log.size() / 2; i++) begin
            a = v.act_base + 8'(i);
            check_output({tag, "_addr_a"}, 32'(addr_log[2*i]), 32'(a));
            a = v.wgt_base + 8'(i);
            check_output({tag, "_addr_w"}, 32'(addr_log[2*i+1]), 32'(a));
        end

        @(negedge clk);
        check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
        check_output({tag, "_hold_score"}, score, v.exp_score);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //        n_bits  thr           abase  wbase  act0          wgt0          act1          wgt1          pop  score         act cyc
        vecs[0] = '{16'd9,  32'd0,        8'h10, 8'h40, 32'h0000_01FF, 32'h0000_01FF, 32'h0,        32'h0,        16'd9,  32'd9,        1'b1, 5};
        vecs[1] = '{16'd9,  32'hFFFF_FFF7, 8'h10, 8'h40, 32'hFFFF_FFFF, 32'hFFFF_FE00, 32'h0,        32'h0,        16'd0,  32'hFFFF_FFF7, 1'b1, 5};
        vecs[2] = '{16'd9,  32'hFFFF_FFF8, 8'h10, 8'h40, 32'hFFFF_FFFF, 32'hFFFF_FE00, 32'h0,        32'h0,        16'd0,  32'hFFFF_FFF7, 1'b0, 5};
        vecs[3] = '{16'd40, 32'd0,        8'h10, 8'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 16'd32, 32'd24,       1'b1, 9};
        vecs[4] = '{16'd0,  32'd1,        8'h10, 8'h40, 32'h0,        32'h0,        32'h0,        32'h0,        16'd0,  32'd0,        1'b0, 1};
        vecs[5] = '{16'd0,  32'd0,        8'h10, 8'h40, 32'h0,        32'h0,        32'h0,        32'h0,        16'd0,  32'd0,        1'b1, 1};
        vecs[6] = '{16'd64, 32'd100,      8'h10, 8'h40, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_FFFF, 32'h0,        16'd48, 32'd32,       1'b0, 9};
        vecs[7] = '{16'd33, 32'd31,       8'hFF, 8'h7F, 32'h0,        32'h0,        32'h1,        32'h0,        16'd32, 32'd31,       1'b1, 9};

        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        reset     = 1'b1;
        start     = 1'b0;
        n_bits    = '0;
        threshold = '0;
        act_base  = '0;
        wgt_base  = '0;
        gnt_en    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_req", 32'(mem_if.mem_req), 32'd0);
        check_output("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        check_output("rst_pop", 32'(pop_count), 32'd0);
        check_output("rst_score", score, 32'd0);
        check_output("rst_act", 32'(act_out), 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i], 0, -1, $sformatf("vec%0d", i));
        end

        apply_stimulus(vecs[0], 3, -1, "gnt_stall");
        apply_stimulus(vecs[3], 0, 3, "start_busy");

        // Reset while the final weight read is in flight.
        mem_arr[8'h10] = vecs[0].act0;
        mem_arr[8'h40] = vecs[0].wgt0;
        @(negedge clk);
        n_bits    = 16'd9;
        threshold = 32'd0;
        act_base  = 8'h10;
        wgt_base  = 8'h40;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_req", 32'(mem_if.mem_req), 32'd0);
        check_output("mid_rst_addr", 32'(mem_if.mem_addr), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        check_output("mid_rst_pop", 32'(pop_count), 32'd0);
        check_output("mid_rst_score", score, 32'd0);
        check_output("mid_rst_act", 32'(act_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_output("post_rst_req", 32'(mem_if.mem_req), 32'd0);
            check_output("post_rst_busy", 32'(busy), 32'd0);
            check_output("post_rst_done", 32'(done), 32'd0);
        end

        apply_stimulus(vecs[6], 0, -1, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_neuron_seq.md
Name: bnn_neuron_seq

Overview:
- Multi-word sequencer for one binary neuron: dot-product over a vector longer than one 32-bit XNOR/popcount word.
- Fetches activation and weight words from a shared word-addressed memory port.
- Per word: XNORs, masks the tail, popcounts and accumulates; then forms the ±1 score and applies the activation threshold.
- Sits beside the single-word BNN unit and is started by a custom instruction; results are read back by the core.

Parameters:
- ADDR_W, 8, memory word-address width; addresses wrap modulo 2^ADDR_W.
- CNT_W, 16, width of n_bits and of the popcount accumulator.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- n_bits  in  CNT_W  vector length in bits; captured on start
- threshold  in  32  signed activation threshold; captured on start
- act_base  in  ADDR_W  first activation word address; captured on start
- wgt_base  in  ADDR_W  first weight word address; captured on start
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; arrives one or more cycles after gnt
- mem_rdata  in  32  read data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; results valid
- pop_count  out  CNT_W  accumulated popcount
- score  out  32  signed, 2*pop_count - n_bits
- act_out  out  1  score >= threshold (signed compare)

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_addr=0, busy=0, done=0, pop_count=0, score=0, act_out=0; word index and accumulator cleared.
- Reset mid-operation: immediate return to IDLE with the values above. Any rvalid still outstanding is ignored.
- Word count W = ceil(n_bits/32). Word i lives at act_base+i and at wgt_base+i (ADDR_W wrap).
- FSM states: IDLE, FETCH_A, WAIT_A, FETCH_W, WAIT_W, FINISH.
- IDLE:
  - start=1 captures config, clears the accumulator and index.
  - Next state FETCH_A, or FINISH if n_bits=0.
  - start is ignored in every other state.
- FETCH_A:
  - mem_req=1, mem_addr=act_base+i.
  - On mem_gnt go to WAIT_A.
  - mem_req and mem_addr hold stable until gnt.
- WAIT_A: mem_req=0. On mem_rvalid latch mem_rdata as the activation word and go to FETCH_W.
- FETCH_W: same as FETCH_A but mem_addr=wgt_base+i; on mem_gnt go to WAIT_W.
- WAIT_W, on mem_rvalid:
  - x = ~(act ^ mem_rdata).
  - For the last word with r = n_bits mod 32 ≠ 0, clear bits [31:r].
  - Add popcount(x) (0..32) to the accumulator.
  - If i = W-1 go to FINISH, else i++ and go to FETCH_A.
- FINISH (one cycle):
  - done=1.
  - pop_count, score and act_out are registered this cycle.
  - Next state IDLE.
- Results hold until the next accepted start, which clears them to 0 one cycle after start.
- Arithmetic:
  - score = (zero-extend(pop_count) << 1) - zero-extend(n_bits), 32-bit two's complement.
  - act_out uses a signed 32-bit compare.
- Latency: with gnt always high and rvalid exactly one cycle after gnt, done is asserted 4W+1 cycles after the start edge. Each gnt or rvalid stall cycle adds one cycle.
- mem_rvalid is ignored outside WAIT_A and WAIT_W.
- Exactly one outstanding read at a time.

Test Plan:
- n_bits=9, act=0x000001FF, wgt=0x000001FF, threshold=0 -> pop_count=9, score=9, act_out=1, done 5 cycles after start.
- n_bits=9, act=0xFFFFFFFF, wgt=0xFFFFFE00, threshold=-9 -> tail masked, pop_count=0, score=-9, act_out=1. Repeat with threshold=-8 -> act_out=0.
- n_bits=40:
  - word0 act=wgt=0xFFFFFFFF; word1 act=0x00000000, wgt=0xFFFFFFFF.
  - Expect pop_count=32, score=24, done at cycle 9.
  - Addresses issued: act_base, wgt_base, act_base+1, wgt_base+1, in order.
- mem_gnt held low 3 cycles on the first FETCH_A -> mem_req and mem_addr stable throughout; done delayed to cycle 8 for n_bits=9.
- start pulsed while busy -> ignored, config unchanged. Reset asserted during WAIT_W -> busy=0, all outputs 0, no mem_req next cycle.
- n_bits=0, threshold=1 -> no mem_req, done 1 cycle after start, score=0, act_out=0. With threshold=0 -> act_out=1.
